// File: rtl/osc_meas_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : osc_meas_pkg
//  Description : Shared types and helpers for the ring-oscillator measurement
//                controller: FSM state encoding, frame header constant and
//                width helpers.
//  Revision    : 1.0  initial release
// ============================================================================
package osc_meas_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GATE  = 3'd1,
        LATCH = 3'd2,
        SEND  = 3'd3,
        HALT  = 3'd4
    } state_t;

    localparam logic [7:0] FRAME_HDR = 8'hA5;

    // Frame = header(8) + seq(8) + timeout mask(8) + all channel counts.
    function automatic int frame_w(input int num_ch, input int cnt_w);
        return 24 + num_ch * cnt_w;
    endfunction

    // Counter width able to hold 0..n-1 (at least one bit).
    function automatic int cnt_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/osc_meas_capture.sv
`default_nettype none
// ============================================================================
//  Module      : osc_meas_capture
//  Description : Per-channel capture slot. Stores the channel count on the
//                first acknowledged cycle while enabled and flags it captured.
//  Revision    : 1.0  initial release
//  Ports       : clk_i, rst_i   clock / synchronous active-high reset
//                clr_i          clears captured flag and stored count
//                en_i           capture window open (controller in LATCH)
//                ack_i          channel acknowledge (level)
//                count_i        channel latched count
//                field_o        effective frame field (all-ones if missing)
//                cap_o          effective captured flag
// ============================================================================
module osc_meas_capture #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             ack_i,
    input  logic [CNT_W-1:0] count_i,
    output logic [CNT_W-1:0] field_o,
    output logic             cap_o
);

    logic [CNT_W-1:0] data_q;
    logic             cap_q;
    logic             w_take;

    assign w_take = en_i & ack_i & ~cap_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            data_q <= '0;
            cap_q  <= 1'b0;
        end else if (w_take) begin
            data_q <= count_i;
            cap_q  <= 1'b1;
        end
    end

    // The effective view includes an ack present in the current cycle, so the
    // controller can close the latch window and build the frame in the same
    // cycle the last ack arrives.
    assign cap_o   = cap_q | w_take;
    assign field_o = cap_q  ? data_q  :
                     w_take ? count_i : {CNT_W{1'b1}};

endmodule
`default_nettype wire

// File: rtl/osc_meas_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : osc_meas_ctrl
//  Description : Measurement controller for ring-oscillator stress tests.
//                Generates gate window, oscillator reset and periodic halt,
//                collects per-channel counts via req/ack with timeout and
//                hands one framed record per sample to the UART transmitter.
//  Revision    : 1.0  initial release
//  Ports       : ref_clk_i, rst_i      clock / synchronous active-high reset
//                osc_rst_o             clears oscillator counters
//                osc_halt_o            stops oscillators
//                osc_latch_req_o       shared latch request
//                osc_latch_ack_i       per-channel acknowledge
//                osc_count_i           latched counts, channel 0 in LSBs
//                tx_start_o            one-cycle frame start
//                tx_data_o             {A5, seq, to_mask, counts}
//                tx_busy_i             transmitter busy
//                err_to_o              sticky timeout flag
//                seq_o                 sequence number of last frame sent
// ============================================================================
module osc_meas_ctrl
    import osc_meas_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int CNT_W    = 32,
    parameter int GATE_CYC = 10000000,
    parameter int ACK_TO   = 64,
    parameter int STP_SMPL = 30,
    parameter int HALT_CYC = 10000000
) (
    input  logic                               ref_clk_i,
    input  logic                               rst_i,
    output logic                               osc_rst_o,
    output logic                               osc_halt_o,
    output logic                               osc_latch_req_o,
    input  logic [NUM_CH-1:0]                  osc_latch_ack_i,
    input  logic [NUM_CH*CNT_W-1:0]            osc_count_i,
    output logic                               tx_start_o,
    output logic [frame_w(NUM_CH, CNT_W)-1:0]  tx_data_o,
    input  logic                               tx_busy_i,
    output logic                               err_to_o,
    output logic [7:0]                         seq_o
);

    localparam int FRAME_W = frame_w(NUM_CH, CNT_W);
    localparam int GATE_W  = cnt_bits(GATE_CYC);
    localparam int TO_W    = cnt_bits(ACK_TO);
    localparam int HALT_W  = cnt_bits(HALT_CYC);
    localparam int IDX_W   = cnt_bits(STP_SMPL + 1);

    state_t              state_q,    state_d;
    logic [GATE_W-1:0]   gate_cnt_q, gate_cnt_d;
    logic [TO_W-1:0]     to_cnt_q,   to_cnt_d;
    logic [HALT_W-1:0]   halt_cnt_q, halt_cnt_d;
    logic [IDX_W-1:0]    idx_q,      idx_d;
    logic                go_halt_q,  go_halt_d;
    logic                osc_rst_q,  osc_rst_d;
    logic                osc_halt_q, osc_halt_d;
    logic                latch_q,    latch_d;
    logic                tx_start_q, tx_start_d;
    logic [FRAME_W-1:0]  tx_data_q,  tx_data_d;
    logic                err_to_q,   err_to_d;
    logic [7:0]          seq_q,      seq_d;

    logic [NUM_CH-1:0]       w_cap;
    logic [NUM_CH*CNT_W-1:0] w_fields;
    logic [7:0]              w_mask8;
    logic                    w_gate_last;
    logic                    w_cap_en;
    logic                    w_all_cap;
    logic                    w_to_last;
    logic                    w_fire;
    logic [IDX_W-1:0]        w_idx_inc;
    logic                    w_idx_wrap;

    assign w_gate_last = (state_q == GATE) && (gate_cnt_q == GATE_W'(GATE_CYC - 1));
    assign w_cap_en    = (state_q == LATCH);

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_cap
            osc_meas_capture #(
                .CNT_W (CNT_W)
            ) u_cap (
                .clk_i   (ref_clk_i),
                .rst_i   (rst_i),
                .clr_i   (w_gate_last),
                .en_i    (w_cap_en),
                .ack_i   (osc_latch_ack_i[i]),
                .count_i (osc_count_i[i*CNT_W +: CNT_W]),
                .field_o (w_fields[i*CNT_W +: CNT_W]),
                .cap_o   (w_cap[i])
            );
        end
    endgenerate

    always_comb begin
        w_mask8               = '0;
        w_mask8[NUM_CH-1:0]   = ~w_cap;
    end

    always_comb begin
        state_d    = state_q;
        w_fire     = 1'b0;
        w_all_cap  = &w_cap;
        w_to_last  = (state_q == LATCH) && (to_cnt_q == TO_W'(ACK_TO - 1));
        w_idx_inc  = idx_q + 1'b1;
        w_idx_wrap = (STP_SMPL != 0) && (w_idx_inc == IDX_W'(STP_SMPL));

        // The transmit decision is taken at the edge that enters (or stays
        // in) SEND so that the registered tx_start is high in the SEND cycle
        // itself; SEND is left on the cycle after the pulse.
        case (state_q)
            IDLE:  state_d = GATE;
            GATE:  if (w_gate_last) state_d = LATCH;
            LATCH: begin
                if (w_all_cap || w_to_last) begin
                    state_d = SEND;
                    w_fire  = ~tx_busy_i;
                end
            end
            SEND: begin
                if (tx_start_q) state_d = go_halt_q ? HALT : GATE;
                else            w_fire  = ~tx_busy_i;
            end
            HALT:  if (halt_cnt_q == HALT_W'(HALT_CYC - 1)) state_d = GATE;
            default: state_d = IDLE;
        endcase

        gate_cnt_d = ((state_q == GATE)  && (state_d == GATE))  ? gate_cnt_q + 1'b1 : '0;
        to_cnt_d   = ((state_q == LATCH) && (state_d == LATCH)) ? to_cnt_q   + 1'b1 : '0;
        halt_cnt_d = ((state_q == HALT)  && (state_d == HALT))  ? halt_cnt_q + 1'b1 : '0;

        idx_d     = idx_q;
        go_halt_d = go_halt_q;
        if (w_fire) begin
            idx_d     = w_idx_wrap ? '0 : w_idx_inc;
            go_halt_d = w_idx_wrap;
        end

        tx_start_d = w_fire;
        tx_data_d  = w_fire ? {FRAME_HDR, seq_q, w_mask8, w_fields} : tx_data_q;
        seq_d      = w_fire ? seq_q + 8'd1 : seq_q;
        err_to_d   = err_to_q | (w_to_last & ~w_all_cap);

        // Outputs are decoded from next-state values so the registered
        // outputs line up with the state they describe.
        osc_rst_d  = (state_d == IDLE) || ((state_d == GATE) && (gate_cnt_d == '0));
        osc_halt_d = (state_d == IDLE) || (state_d == HALT);
        latch_d    = (state_d == LATCH);
    end

    always_ff @(posedge ref_clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            gate_cnt_q <= '0;
            to_cnt_q   <= '0;
            halt_cnt_q <= '0;
            idx_q      <= '0;
            go_halt_q  <= 1'b0;
            osc_rst_q  <= 1'b1;
            osc_halt_q <= 1'b1;
            latch_q    <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            err_to_q   <= 1'b0;
            seq_q      <= '0;
        end else begin
            state_q    <= state_d;
            gate_cnt_q <= gate_cnt_d;
            to_cnt_q   <= to_cnt_d;
            halt_cnt_q <= halt_cnt_d;
            idx_q      <= idx_d;
            go_halt_q  <= go_halt_d;
            osc_rst_q  <= osc_rst_d;
            osc_halt_q <= osc_halt_d;
            latch_q    <= latch_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            err_to_q   <= err_to_d;
            seq_q      <= seq_d;
        end
    end

    assign osc_rst_o       = osc_rst_q;
    assign osc_halt_o      = osc_halt_q;
    assign osc_latch_req_o = latch_q;
    assign tx_start_o      = tx_start_q;
    assign tx_data_o       = tx_data_q;
    assign err_to_o        = err_to_q;
    assign seq_o           = seq_q;

endmodule
`default_nettype wire

// File: tb/tb_osc_meas_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_osc_meas_ctrl
//  Description : Self-checking bench for osc_meas_ctrl. Each sample is driven
//                with a chosen ack delay per channel, count values and
//                transmitter back-pressure; expected gate/latch/frame/halt
//                timing and frame contents come from a sample-level model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_osc_meas_ctrl;

    localparam int NUM_CH   = 2;
    localparam int CNT_W    = 32;
    localparam int GATE_CYC = 100;
    localparam int ACK_TO   = 16;
    localparam int STP_SMPL = 3;
    localparam int HALT_CYC = 50;
    localparam int FRAME_W  = 24 + NUM_CH * CNT_W;
    localparam int NEVER    = 1000;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [NUM_CH-1:0]       ack = '0;
    logic [NUM_CH*CNT_W-1:0] count = '0;
    logic                    tx_busy = 1'b0;
    logic                    osc_rst, osc_halt, latch_req, tx_start, err_to;
    logic [FRAME_W-1:0]      tx_data;
    logic [7:0]              seq;

    int unsigned cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;

    // Model state
    int          exp_seq  = 0;
    bit          exp_err  = 1'b0;
    int          nsamp    = 0;

    osc_meas_ctrl #(
        .NUM_CH   (NUM_CH),
        .CNT_W    (CNT_W),
        .GATE_CYC (GATE_CYC),
        .ACK_TO   (ACK_TO),
        .STP_SMPL (STP_SMPL),
        .HALT_CYC (HALT_CYC)
    ) u_dut (
        .ref_clk_i       (clk),
        .rst_i           (rst),
        .osc_rst_o       (osc_rst),
        .osc_halt_o      (osc_halt),
        .osc_latch_req_o (latch_req),
        .osc_latch_ack_i (ack),
        .osc_count_i     (count),
        .tx_start_o      (tx_start),
        .tx_data_o       (tx_data),
        .tx_busy_i       (tx_busy),
        .err_to_o        (err_to),
        .seq_o           (seq)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Advance one clock; observe and drive 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // One complete sample, entered on its first GATE cycle.
    //   d0/d1 : cycles after the request rise at which each ack goes high
    //   bsy   : extra cycles tx_busy stays high once SEND is reached
    task automatic run_sample(input int d0, input int d1,
                              input logic [31:0] c0, input logic [31:0] c1,
                              input bit rnd_cnt, input int bsy);
        int d[NUM_CH];
        logic [31:0] cap [NUM_CH];
        logic [7:0]  mask;
        logic [FRAME_W-1:0] frame;
        int g0, l0, s0, r, rst_cnt, expL, exp_ts, hc, wt;
        bit timeout, halted;
        d[0] = d0; d[1] = d1;
        cap[0] = '0; cap[1] = '0;

        chk_val("gate_start", {osc_rst, osc_halt}, 2'b10);
        g0 = cyc; rst_cnt = 0;
        ack = '0;
        count = {c1, c0};
        tx_busy = (bsy > 0);

        wt = 0;
        while (!latch_req && wt < 400) begin
            rst_cnt += int'(osc_rst);
            step();
            wt++;
        end
        chk_val("gate_len", cyc - g0, GATE_CYC);
        chk_val("rst_pulses", rst_cnt, 1);

        // Latch window: ack i is high from cycle d[i] onward; the count
        // present in that cycle is the one the frame must carry.
        l0 = cyc; r = 0;
        while (latch_req && r < 40) begin
            if (rnd_cnt) count = {$urandom, $urandom};
            for (int i = 0; i < NUM_CH; i++) begin
                ack[i] = (r >= d[i]);
                if (r == d[i]) cap[i] = count[i*CNT_W +: CNT_W];
            end
            step();
            r++;
        end
        timeout = 1'b0;
        for (int i = 0; i < NUM_CH; i++) if (d[i] >= ACK_TO) timeout = 1'b1;
        expL = timeout ? ACK_TO : ((d0 > d1 ? d0 : d1) + 1);
        chk_val("latch_len", cyc - l0, expL);

        mask = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (d[i] >= ACK_TO) begin
                mask[i] = 1'b1;
                cap[i]  = '1;
            end
        end
        frame = {8'hA5, 8'(exp_seq), mask, cap[1], cap[0]};

        // The pulse is registered on the first edge that samples tx_busy low.
        s0 = cyc;
        exp_ts = (bsy > 0) ? s0 + bsy + 1 : s0;
        wt = 0;
        while (cyc < exp_ts && wt < 100) begin
            chk_val("send_quiet", {tx_start, latch_req, osc_rst, osc_halt}, 4'b0000);
            step();
            wt++;
            if (cyc >= s0 + bsy) tx_busy = 1'b0;
        end
        tx_busy = 1'b0;

        chk_val("tx_start", tx_start, 1'b1);
        chk_val("tx_data", tx_data, frame);
        exp_seq = (exp_seq + 1) % 256;
        chk_val("seq", seq, 8'(exp_seq));
        if (timeout) exp_err = 1'b1;
        chk_val("err_to", err_to, exp_err);

        nsamp++;
        halted = (nsamp == STP_SMPL);
        if (halted) nsamp = 0;

        step();
        chk_val("tx_pulse_1cyc", tx_start, 1'b0);
        chk_val("tx_hold", tx_data, frame);
        if (halted) begin
            hc = 0;
            while (osc_halt && hc < 200) begin
                step();
                hc++;
            end
            chk_val("halt_len", hc + 1, HALT_CYC + 1);
        end else begin
            chk_val("no_halt", osc_halt, 1'b0);
        end
        chk_val("period", cyc - g0,
                GATE_CYC + expL + ((bsy > 0) ? bsy + 1 : 0) + 1 + (halted ? HALT_CYC : 0));
    endtask

    initial begin
        int wt;
        rst = 1'b1;
        repeat (3) step();
        chk_val("reset_vals", {osc_rst, osc_halt, latch_req, tx_start, err_to, seq, tx_data},
                {4'b1100, 1'b0, 8'h00, {FRAME_W{1'b0}}});
        rst = 1'b0;
        step();

        // Fixed counts, both acks 2 cycles after the request.
        run_sample(2, 2, 32'h0000_1234, 32'h0000_5678, 1'b0, 0);
        // Channel 1 never acks.
        run_sample(1, NEVER, 32'hDEAD_0001, 32'hBEEF_0002, 1'b1, 0);
        // Both acks on the timeout cycle; third sample -> halt.
        run_sample(ACK_TO - 1, ACK_TO - 1, 32'h0, 32'h0, 1'b1, 0);
        // Back-pressure at SEND.
        run_sample(0, 3, 32'hCAFE_F00D, 32'h0BAD_BEEF, 1'b0, 40);

        for (int n = 0; n < 12; n++) begin
            run_sample($urandom_range(0, 19), $urandom_range(0, 19),
                       $urandom, $urandom, 1'b1,
                       ($urandom_range(0, 3) == 0) ? $urandom_range(1, 12) : 0);
        end

        // Reset in the middle of LATCH.
        ack = '0;
        wt = 0;
        while (!latch_req && wt < 400) begin
            step();
            wt++;
        end
        chk_val("reach_latch", latch_req, 1'b1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_val("mid_reset_vals", {osc_rst, osc_halt, latch_req, tx_start, err_to, seq, tx_data},
                {4'b1100, 1'b0, 8'h00, {FRAME_W{1'b0}}});
        exp_seq = 0; exp_err = 1'b0; nsamp = 0;
        step();
        run_sample(1, 0, 32'h1111_2222, 32'h3333_4444, 1'b0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/osc_meas_ctrl.md
# osc_meas_ctrl

Parametrised measurement controller for GPIO ring-oscillator stress tests. It generates the gate window, oscillator reset and periodic halt for up to 8 oscillator channels. It collects latched counts through a per-channel request/acknowledge handshake with a timeout, and hands one framed record per sample to the UART transmitter. It sits between the `osc` channel instances and `uart_tx`, and replaces the fixed two-channel gating logic in the top level.

## Interface
- `NUM_CH`, 2: oscillator channels, 1..8.
- `CNT_W`, 32: count width per channel, multiple of 8, 8..32.
- `GATE_CYC`, 10000000: gate length in `ref_clk` cycles, ≥2.
- `ACK_TO`, 64: maximum `LATCH` cycles before timeout, ≥1.
- `STP_SMPL`, 30: samples between halts; 0 disables halting.
- `HALT_CYC`, 10000000: halt duration in cycles, ≥1.
- `FRAME_W`, derived: 24+NUM_CH*CNT_W; not overridable.
- `ref_clk`  in  1  clock; the block has one clock.
- `rst`  in  1  synchronous, active-high reset.
- `osc_rst`  out  1  clears oscillator counters.
- `osc_halt`  out  1  stops oscillators.
- `osc_latch_req`  out  1  latch request, shared by all channels.
- `osc_latch_ack`  in  NUM_CH  per-channel acknowledge, level.
- `osc_count`  in  NUM_CH*CNT_W  latched counts; channel 0 in the LSBs.
- `tx_start`  out  1  one-cycle frame start pulse.
- `tx_data`  out  FRAME_W  frame: {8'hA5, seq[7:0], to_mask padded to 8 bits, counts}.
- `tx_busy`  in  1  transmitter busy.
- `err_to`  out  1  sticky; set by any timeout.
- `seq`  out  8  sequence number of the last frame sent.

## Operation
- All outputs are registered.
- Reset values:
  - `osc_rst`=1, `osc_halt`=1
  - `osc_latch_req`=0, `tx_start`=0
  - `tx_data`=0, `err_to`=0, `seq`=0
  - state `IDLE`, sample index 0
- `rst` wins over all other events in the same cycle. Reset mid-operation aborts any pending frame; no `tx_start` is issued.
- States:
  - `IDLE`: one cycle after reset release, then `GATE`.
  - `GATE`: gate counter runs 0..GATE_CYC-1.
    - `osc_rst`=1 only at count 0.
    - `osc_halt`=0.
    - At count GATE_CYC-1, go to `LATCH`.
  - `LATCH`: `osc_latch_req`=1, timeout counter runs.
    - In any cycle where channel i has ack=1 and is not yet captured, store `osc_count[i]` and set its captured bit.
    - When all channels are captured: go to `SEND`.
    - If the timeout counter reaches ACK_TO-1 first: go to `SEND`.
      - Uncaptured channels get field = all-ones and their `to_mask` bit set.
      - `err_to` is set.
  - `SEND`: `osc_latch_req`=0.
    - Wait while `tx_busy`=1.
    - On the first cycle with `tx_busy`=0: pulse `tx_start`, load `tx_data`, increment `seq` (wraps 255→0), increment the sample index.
    - Next state: `HALT` if STP_SMPL≠0 and the new index = STP_SMPL (index then clears to 0); otherwise `GATE`.
  - `HALT`: `osc_halt`=1 for exactly HALT_CYC cycles, then `GATE`.
- Captured bits clear on entry to `LATCH`.
- An ack already high on the first `LATCH` cycle is captured in that cycle.
- An ack that rises on the cycle the timeout fires counts as captured.
- While in `SEND`, gating is paused. Frames are never dropped or overwritten.
- `tx_data` holds its value until the next `tx_start`.
- Count fields are passed unmodified. No arithmetic is applied beyond the wrapping counters.

## Timing
- Gate window: exactly GATE_CYC cycles per sample.
- `osc_latch_req` rises in the cycle after the last `GATE` cycle.
- With all acks arriving k cycles after the request (k<ACK_TO): `osc_latch_req` falls k+1 cycles after rising.
- With `tx_busy`=0, `tx_start` follows `osc_latch_req` falling by 0 cycles; it is asserted in the first `SEND` cycle.
- Timeout: `osc_latch_req` is high for exactly ACK_TO cycles.
- Sample period without back-pressure: GATE_CYC + (k+1) + 1 cycles.

## Structure
- Package `osc_meas_pkg`:
  - state enum: `IDLE`, `GATE`, `LATCH`, `SEND`, `HALT`
  - `FRAME_HDR` = 8'hA5
  - function computing FRAME_W
- Sub-module `osc_meas_capture`: one instance per channel.
  - Contains the capture register and captured bit.
  - Clear input, enable input, ack input; outputs the count field and captured flag.
  - Generated NUM_CH times.

## Test plan
Common setup: NUM_CH=2, CNT_W=32, GATE_CYC=100, ACK_TO=16, STP_SMPL=3, HALT_CYC=50.
- Reset, then both acks 2 cycles after the request, counts 0x1234/0x5678:
  - `osc_rst` pulses once per sample.
  - `tx_data`={A5,00,00,00005678,00001234}.
  - `seq`=1 after the first frame; sample period 104 cycles.
- Channel 1 never acks:
  - Request high for 16 cycles.
  - Frame mask=0x02, ch1 field=FFFFFFFF.
  - `err_to`=1 and stays 1 through later good samples.
- Three samples sent: `osc_halt` high for exactly 50 cycles after the third `tx_start`, then `GATE` resumes with an `osc_rst` pulse.
- `tx_busy` held high 40 cycles at `SEND`:
  - `tx_start` is asserted in the first cycle `tx_busy` is low.
  - No gate activity meanwhile; no frame lost.
- Ack arriving simultaneously with the timeout cycle: that channel is counted as captured, mask bit clear.
- `rst` asserted mid-`LATCH`:
  - Next cycle, all outputs are at their reset values.
  - No `tx_start`; `seq` returns to 0.
